// File: rtl/tx_hold_timer.sv
// Per-channel hold-to-fire timers feeding a round-robin valid/ready event port.
// Optional macro TX_HOLD_TIMER_REPEAT_EN enables auto-repeat while held.
module tx_hold_timer #(
  parameter int NUM_CH        = 4,
  parameter int HOLD_CYCLES   = 10,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic                                     i_Clk,
  input  logic                                     i_Rst,
  input  logic [NUM_CH-1:0]                        i_Stable,
  output logic [NUM_CH-1:0]                        o_Transmit,
  output logic                                     o_Valid,
  output logic [(NUM_CH>1?$clog2(NUM_CH):1)-1:0]   o_Ch,
  input  logic                                     i_Ready,
  output logic [NUM_CH-1:0]                        o_Drop
);

  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int NW   = $clog2(MAXC) + 1;
  localparam logic [NW-1:0] HOLD_M1 = NW'(HOLD_CYCLES - 1);
`ifdef TX_HOLD_TIMER_REPEAT_EN
  localparam logic [NW-1:0] REP_M1  = NW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HELD} state_t;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [NW-1:0]     r_cnt       [NUM_CH];
  logic [NW-1:0]     w_cnt_nxt   [NUM_CH];

  logic [NUM_CH-1:0] w_fire;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_tx;
  logic [NUM_CH-1:0] r_drop;
  logic              r_valid;
  logic [CW-1:0]     r_ch;
  logic [CW-1:0]     r_ptr;
  logic [CW-1:0]     w_ptr_nxt;
  logic [CW-1:0]     w_ch_nxt;
  logic              w_xfer;
  logic              w_lock;
  logic              w_found;
  int                w_idx;

  assign o_Transmit = r_tx;
  assign o_Drop     = r_drop;
  assign o_Valid    = r_valid;
  assign o_Ch       = r_ch;

  // Per-channel hold FSM: count consecutive highs, fire on the final one.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c];
      w_fire[c]      = 1'b0;
      unique case (r_state[c])
        S_IDLE: begin
          if (i_Stable[c]) begin
            w_state_nxt[c] = S_COUNT;
            w_cnt_nxt[c]   = NW'(1);
          end
        end
        S_COUNT: begin
          if (!i_Stable[c]) begin
            w_state_nxt[c] = S_IDLE;
            w_cnt_nxt[c]   = '0;
          end else if (r_cnt[c] == HOLD_M1) begin
            w_state_nxt[c] = S_HELD;
            w_cnt_nxt[c]   = '0;
            w_fire[c]      = 1'b1;
          end else begin
            w_cnt_nxt[c]   = r_cnt[c] + NW'(1);
          end
        end
        S_HELD: begin
          if (!i_Stable[c]) begin
            w_state_nxt[c] = S_IDLE;
            w_cnt_nxt[c]   = '0;
          end
`ifdef TX_HOLD_TIMER_REPEAT_EN
          else if (r_cnt[c] == REP_M1) begin
            w_cnt_nxt[c]   = '0;
            w_fire[c]      = 1'b1;
          end else begin
            w_cnt_nxt[c]   = r_cnt[c] + NW'(1);
          end
`endif
        end
        default: begin
          w_state_nxt[c] = S_IDLE;
          w_cnt_nxt[c]   = '0;
        end
      endcase
    end
  end

  // Pending set/clear, drop detection and round-robin grant with lock.
  always_comb begin
    w_xfer    = r_valid & i_Ready;
    w_lock    = r_valid & ~i_Ready;
    w_clr     = '0;
    w_ptr_nxt = r_ptr;
    if (w_xfer) begin
      w_clr[r_ch] = 1'b1;
      w_ptr_nxt   = (int'(r_ch) == NUM_CH - 1) ? '0 : r_ch + CW'(1);
    end
    w_drop     = w_fire & r_pend & ~w_clr;
    w_pend_nxt = (r_pend & ~w_clr) | w_fire;
    w_ch_nxt   = r_ch;
    w_found    = 1'b0;
    w_idx      = 0;
    if (!w_lock) begin
      w_ch_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        w_idx = (int'(w_ptr_nxt) + i) % NUM_CH;
        if (!w_found && w_pend_nxt[w_idx]) begin
          w_ch_nxt = CW'(w_idx);
          w_found  = 1'b1;
        end
      end
    end
  end

  // State, counters, pending flags and registered event port.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= S_IDLE;
        r_cnt[c]   <= '0;
      end
      r_pend  <= '0;
      r_tx    <= '0;
      r_drop  <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
      end
      r_pend  <= w_pend_nxt;
      r_tx    <= w_fire;
      r_drop  <= w_drop;
      r_valid <= |w_pend_nxt;
      r_ch    <= w_ch_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_tx_hold_timer.sv
// Randomized scoreboard bench for tx_hold_timer against a run-length model.
// Honors TX_HOLD_TIMER_REPEAT_EN the same way as the design.
module tb_tx_hold_timer;

  localparam int NCH  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 20;
`ifdef TX_HOLD_TIMER_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  typedef struct packed {
    int       cyc;
    logic [3:0] tx;
    logic [3:0] dr;
  } tx_t;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
  } pres_t;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [3:0] i_Stable = '0;
  logic       i_Ready = 1'b0;
  logic [3:0] o_Transmit;
  logic [3:0] o_Drop;
  logic       o_Valid;
  logic [1:0] o_Ch;

  tx_t   q_tx[$];
  pres_t q_pres[$];

  int cyc  = 0;
  int nvec = 0;
  int nchk = 0;
  int nerr = 0;

  int       run [NCH];
  bit [3:0] pend;
  int       ptr;
  bit       m_valid;
  int       m_ch;

  tx_hold_timer #(
    .NUM_CH(NCH),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .i_Clk(clk),
    .i_Rst(i_Rst),
    .i_Stable(i_Stable),
    .o_Transmit(o_Transmit),
    .o_Valid(o_Valid),
    .o_Ch(o_Ch),
    .i_Ready(i_Ready),
    .o_Drop(o_Drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int rr_pick(input bit [3:0] p, input int start);
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (start + i) % NCH;
      if (p[k]) return k;
    end
    return 0;
  endfunction

  // One cycle of stimulus; the model predicts what the next edge produces.
  task automatic step(input logic [3:0] st, input logic rdy, input logic rst);
    tx_t      e;
    bit [3:0] fire;
    bit [3:0] drop;
    bit       xfer;
    int       xch;
    @(posedge clk);
    #1;
    i_Stable = st;
    i_Ready  = rdy;
    i_Rst    = rst;
    nvec++;
    q_pres.push_back('{v: m_valid, ch: 2'(m_ch)});
    if (rst) begin
      for (int c = 0; c < NCH; c++) run[c] = 0;
      pend    = '0;
      ptr     = 0;
      m_valid = 1'b0;
      m_ch    = 0;
    end else begin
      fire = '0;
      drop = '0;
      xfer = m_valid && rdy;
      xch  = m_ch;
      for (int c = 0; c < NCH; c++) begin
        run[c] = st[c] ? run[c] + 1 : 0;
        if (run[c] == HOLD)
          fire[c] = 1'b1;
        if (REP_ON && run[c] > HOLD && ((run[c] - HOLD) % REP) == 0)
          fire[c] = 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        if (fire[c] && pend[c] && !(xfer && xch == c))
          drop[c] = 1'b1;
        if (xfer && xch == c && !fire[c])
          pend[c] = 1'b0;
        if (fire[c])
          pend[c] = 1'b1;
      end
      if (xfer)
        ptr = (xch + 1) % NCH;
      if (fire != 0) begin
        e.cyc = cyc + 1;
        e.tx  = fire;
        e.dr  = drop;
        q_tx.push_back(e);
      end
      if (!(m_valid && !rdy))
        m_ch = rr_pick(pend, ptr);
      m_valid = (pend != 0);
    end
  endtask

  // Monitor: compare presented events and fire pulses with the scoreboard.
  always @(negedge clk) begin
    pres_t p;
    tx_t   e;
    bit    has_exp;
    bit    has_act;
    if (q_pres.size() > 0) begin
      p = q_pres.pop_front();
      nchk++;
      if (o_Valid !== p.v || (p.v && o_Ch !== p.ch)) begin
        nerr++;
        $display("FAIL present cyc=%0d got v=%b ch=%0d want v=%b ch=%0d",
                 cyc, o_Valid, o_Ch, p.v, p.ch);
      end
    end
    has_exp = (q_tx.size() > 0) && (q_tx[0].cyc == cyc);
    has_act = (o_Transmit !== 4'b0) || (o_Drop !== 4'b0);
    if (has_exp || has_act) begin
      nchk++;
      if (has_exp) e = q_tx.pop_front();
      else begin
        e.cyc = cyc;
        e.tx  = '0;
        e.dr  = '0;
      end
      if (o_Transmit !== e.tx || o_Drop !== e.dr) begin
        nerr++;
        $display("FAIL fire cyc=%0d got tx=%b drop=%b want tx=%b drop=%b",
                 cyc, o_Transmit, o_Drop, e.tx, e.dr);
      end
    end
  end

  initial begin
    logic [3:0] st;
    logic       rdy;
    int         rdy_pct;
    for (int c = 0; c < NCH; c++) run[c] = 0;
    pend    = '0;
    ptr     = 0;
    m_valid = 1'b0;
    m_ch    = 0;
    @(posedge clk);
    repeat (3) step(4'h0, 1'b0, 1'b1);
    repeat (3) step(4'h0, 1'b1, 1'b0);
    // short hold: no fire
    repeat (9) step(4'h1, 1'b1, 1'b0);
    repeat (4) step(4'h0, 1'b1, 1'b0);
    // long hold with consumer ready
    repeat (30) step(4'h1, 1'b1, 1'b0);
    repeat (4) step(4'h0, 1'b1, 1'b0);
    // two channels fire together, consumer stalls
    repeat (15) step(4'ha, 1'b0, 1'b0);
    repeat (4) step(4'ha, 1'b1, 1'b0);
    repeat (4) step(4'h0, 1'b1, 1'b0);
    // stalled channel held long enough to repeat
    repeat (36) step(4'h4, 1'b0, 1'b0);
    repeat (4) step(4'h0, 1'b1, 1'b0);
    // reset in the middle of a count
    repeat (4) step(4'h1, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b1);
    repeat (14) step(4'h1, 1'b1, 1'b0);
    repeat (3) step(4'h0, 1'b1, 1'b0);
    // random phase
    st = '0;
    rdy_pct = 75;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) rdy_pct = $urandom_range(5, 100);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 13) == 0) st[c] = ~st[c];
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      step(st, rdy, ($urandom_range(0, 499) == 0));
    end
    repeat (8) step(4'h0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if (q_tx.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d leftover fire events want 0", q_tx.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tx_hold_timer.md
TX_HOLD_TIMER -- requirements
Module: tx_hold_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent trigger channels (1..16).
REQ-002 Parameter HOLD_CYCLES, default 10, consecutive high samples required to fire (2..65535).
REQ-003 Parameter REPEAT_CYCLES, default 100, auto-repeat period in cycles while held (2..65535); used only with TX_HOLD_TIMER_REPEAT_EN.
REQ-004 i_Clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_Rst  input  1  reset, synchronous and active-high.
REQ-006 i_Stable  input  NUM_CH  per-channel level; high = request held, pre-synchronised to i_Clk.
REQ-007 o_Transmit  output  NUM_CH  per-channel one-cycle fire pulse.
REQ-008 o_Valid  output  1  at least one pending fire event is presented.
REQ-009 o_Ch  output  clog2(NUM_CH), min 1  channel index of presented event.
REQ-010 i_Ready  input  1  consumer accepts presented event when high with o_Valid.
REQ-011 o_Drop  output  NUM_CH  one-cycle pulse: fire lost because channel already pending.

Function
REQ-012 Each channel SHALL run an independent FSM: IDLE, COUNT, HELD; counter width clog2(max(HOLD_CYCLES,REPEAT_CYCLES))+1.
REQ-013 IDLE: counter 0; i_Stable=1 sampled -> COUNT with counter 1.
REQ-014 COUNT: i_Stable=0 -> IDLE, counter 0 (no fire); i_Stable=1 and counter=HOLD_CYCLES-1 -> HELD, fire; else counter+1.
REQ-015 Fire SHALL drive o_Transmit[ch] high for exactly the cycle after the edge sampling the HOLD_CYCLES-th consecutive high.
REQ-016 HELD: i_Stable=0 -> IDLE, counter 0; no further fire while held unless REQ-026 applies.
REQ-017 Fire SHALL set pend[ch]; if pend[ch] already set and not cleared that cycle, pend stays set and o_Drop[ch] pulses with o_Transmit[ch].
REQ-018 o_Valid = OR of pend; o_Ch = index granted by round-robin starting at pointer ptr, lowest index at or after ptr wins.
REQ-019 Transfer = o_Valid & i_Ready: clears pend[o_Ch], ptr <= o_Ch+1 modulo NUM_CH.
REQ-020 While o_Valid & !i_Ready, o_Ch SHALL be held constant (grant locked) even if other channels fire.
REQ-021 Fire and transfer on same channel in same cycle: pend remains set, no o_Drop.
REQ-022 o_Valid, o_Ch registered; a fire presents at earliest in the cycle o_Transmit is high.
REQ-023 NUM_CH=1: o_Ch constant 0, ptr unused.

Reset
REQ-024 i_Rst high at a rising edge SHALL force all FSMs to IDLE, counters 0, pend 0, ptr 0, o_Transmit 0, o_Valid 0, o_Ch 0, o_Drop 0, next cycle.
REQ-025 Reset mid-COUNT or mid-handshake SHALL discard progress and pending events; counting restarts from first high sample after i_Rst low.

Configuration
REQ-026 With TX_HOLD_TIMER_REPEAT_EN defined: in HELD, counter restarts at 0 on entry and fires again every REPEAT_CYCLES cycles while i_Stable stays high (REQ-015/017 apply to each repeat).
REQ-027 Without TX_HOLD_TIMER_REPEAT_EN: HELD holds with no counting, REPEAT_CYCLES ignored, single fire per hold.

Verification (NUM_CH=4, HOLD_CYCLES=10, REPEAT_CYCLES=20, 10 ns clock)
REQ-028 ch0 high 9 samples then low -> o_Transmit 0, o_Valid 0 throughout.
REQ-029 ch0 high 30 samples, i_Ready=1, repeat off -> one o_Transmit[0] pulse after 10th sample, o_Valid one cycle with o_Ch=0; repeat on -> further pulses 20 and 40 cycles later if still high.
REQ-030 ch1 and ch3 fire same cycle, i_Ready=0 for 5 cycles then 1 -> o_Ch=1 held 5 cycles, transfer, then o_Ch=3, then o_Valid 0.
REQ-031 ch2 fires, i_Ready=0, repeat on, held 25 cycles past first fire -> second fire raises o_Drop[2], pend[2] still 1.
REQ-032 i_Rst pulsed at 5th high sample of ch0, i_Stable stays high -> all outputs 0; o_Transmit[0] after 10th sample following reset release.
